v810_intc: RTL
==============

# v810_intc

Interrupt controller that sits between the system's peripheral interrupt sources and the `v810` core's `INT` / `INTVn[3:0]` / `NMIn` pins. It latches and masks 16 maskable request lines, selects the highest-priority pending one and presents its level as the interrupt vector. It also shapes a single NMI request into a fixed-width active-low pulse. A small 32-bit register port lets the CPU read pending state, write-1-to-clear edge requests, and program the mask and trigger mode.

## Interface
- `NMI_PULSE`, default 4: number of CE cycles `NMIn` is held low per NMI event; legal range 1..15.
- `CLK` in 1: system clock.
- `RESn` in 1: asynchronous active-low reset.
- `CE` in 1: clock enable; all state advances only on `CLK` rising edges where `CE`=1.
- `IRQ` in 16: request lines; bit i requests level i; 15 is the highest priority.
- `NMI_REQ` in 1: NMI request, active-high, rising-edge sensitive.
- `CSn` in 1: register select, active-low.
- `WEn` in 1: write strobe, active-low; qualified by `CSn`=0.
- `A` in 2: register index: 0 PEND, 1 MASK, 2 EDGE, 3 STAT.
- `DI` in 32: write data; only bits [15:0] are used.
- `DO` out 32: registered read data.
- `INT` out 1: maskable interrupt request to the core.
- `INTVn` out 4: active-low level of the winning source.
- `NMIn` out 1: active-low NMI to the core.

## Operation
- Reset values: `INT`=0, `INTVn`=4'hF, `NMIn`=1, `DO`=0, PEND/MASK/EDGE=0, NMI counter=0.
- Each IRQ bit is sampled into `irq_q` every CE cycle.
- **Level mode** (EDGE[i]=0): PEND[i] is loaded from `irq_q[i]` every CE cycle. A W1C write has no lasting effect.
- **Edge mode** (EDGE[i]=1): PEND[i] sets when `irq_q[i]` is 1 and its previous value was 0. It clears on a write to PEND with DI[i]=1.
- **Simultaneous edge and clear:** when a new edge and a W1C clear hit the same bit in the same cycle, the set wins.
- **Priority:**
  - act = PEND & MASK.
  - `INT` = |act.
  - `INTVn` = ~(index of the highest set bit of act).
  - When act=0, `INTVn` is 4'hF.
  - Both outputs are registered.
- **Mode switch:** writing EDGE changes the mode of each bit. The switched bit's PEND is left unchanged until the next sample.
- **Register reads:**
  - PEND, MASK and EDGE read back in [15:0]; [31:16] read 0.
  - STAT returns {27'b0, `INT`, ~`INTVn`}.
  - `DO` holds its value when not selected.
- **NMI:**
  - A rising edge of sampled `NMI_REQ`, seen while the counter is 0, loads the counter with `NMI_PULSE`.
  - `NMIn` = (counter==0), registered.
  - The counter decrements each CE cycle until it reaches 0.
  - Edges that arrive while the counter is nonzero are ignored.
  - NMI is not maskable and not affected by any register.
- **CE=0:** all registers hold, including the NMI counter and `DO`.
- **Reset mid-operation:** all state returns to reset values immediately. `NMIn` releases to 1 even if a pulse is in flight.

## Timing
- IRQ-to-PEND path:
  - Without sync, IRQ high before CE edge k gives `irq_q`=1 at k.
  - In edge mode PEND is set at k+1, and `INT`/`INTVn` are valid at k+2.
  - In level mode the timing is the same: `irq_q` at k, PEND at k+1, output at k+2.
- A write to MASK or PEND at CE edge k is reflected on `INT`/`INTVn` at k+1.
- A read (CSn=0, WEn=1) at edge k gives `DO` valid after edge k.
- A read at k followed by a write at k sees the pre-write value.
- `NMI_REQ` rising before edge k (sampled at k):
  - the counter loads at k+1 and `NMIn` goes 0 after k+2;
  - `NMIn` stays low for exactly `NMI_PULSE` CE cycles.
- `INT` deasserts at most 1 CE cycle after act becomes 0. Software must clear PEND before EI.

## Configuration
- `V810_INTC_SYNC_EN`: when defined, `IRQ` and `NMI_REQ` pass through two-flop synchronizers ahead of `irq_q` / NMI sampling. This adds 2 CE cycles to every input latency in Timing.
- When undefined, inputs are assumed synchronous to `CLK` and sampled directly.
- Register-path latencies are unaffected either way.

## Structure
- Package `v810_intc_pkg` holds:
  - register index constants (`INTC_PEND`=0, `INTC_MASK`=1, `INTC_EDGE`=2, `INTC_STAT`=3);
  - a `intc_src_t` 16-bit typedef;
  - the NMI counter width (4).
- Sub-module `v810_intc_prio`: combinational 16-to-4 highest-bit encoder with a valid output. It is instantiated once.
- The top level holds the sample, PEND, MASK, EDGE and NMI registers, plus the register port.

## Test plan
- **Level priority:** MASK=16'hFFFF, EDGE=0, IRQ=16'h0120.
  - Required: `INT`=1 and `INTVn`=~4'd8 two CE cycles after IRQ is applied.
  - Then drop IRQ[8]: `INTVn`=~4'd5.
- **Edge latch:** EDGE=16'h0400, MASK=16'h0400, pulse IRQ[10] for 1 cycle.
  - Required: PEND reads 16'h0400 and `INT`=1 persists.
  - Write PEND=16'h0400: `INT`=0 one cycle later.
- **Set-beats-clear:** with EDGE[3]=1, rising IRQ[3] in the same cycle as a W1C write of 16'h0008.
  - Required: PEND[3]=1 afterwards.
- **Masking:** IRQ=16'h8000, MASK=0 gives `INT`=0 and STAT=0.
  - Write MASK=16'h8000: STAT=32'h1F next cycle.
- **NMI pulse:** `NMI_PULSE`=4, `NMI_REQ` high for 10 cycles.
  - Required: `NMIn` low exactly 4 CE cycles, then 1; no second pulse.
  - With CE toggling 50%, the pulse spans 4 enabled cycles.
- **Async reset:** assert `RESn`=0 mid NMI pulse with PEND=16'hFFFF.
  - Required: `NMIn`=1, `INT`=0, `INTVn`=4'hF and PEND=0 before the next `CLK` edge.

Source files
------------

// File: rtl/v810_intc_pkg.sv
// Shared definitions for the v810 interrupt controller: register indices,
// the 16-bit source vector type and the NMI pulse counter width.
package v810_intc_pkg;

    localparam int INTC_NSRC   = 16;
    localparam int INTC_NMI_CW = 4;

    localparam logic [1:0] INTC_PEND = 2'd0;
    localparam logic [1:0] INTC_MASK = 2'd1;
    localparam logic [1:0] INTC_EDGE = 2'd2;
    localparam logic [1:0] INTC_STAT = 2'd3;

    typedef logic [INTC_NSRC-1:0]   intc_src_t;
    typedef logic [INTC_NMI_CW-1:0] intc_nmi_cnt_t;

    // Register-port view of a 16-bit source vector; the upper half always reads 0.
    function automatic logic [31:0] intc_zext(input intc_src_t v);
        return {16'b0, v};
    endfunction

endpackage

// File: rtl/v810_intc_prio.sv
// Combinational highest-set-bit encoder for the 16 maskable sources;
// valid_o flags that at least one source is active.
module v810_intc_prio
    import v810_intc_pkg::*;
(
    input  intc_src_t   src_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        idx_o = 4'd0;
        for (int i = 0; i < INTC_NSRC; i++) begin
            if (src_i[i]) begin
                idx_o = 4'(i);
            end
        end
    end

    assign valid_o = |src_i;

endmodule

// File: rtl/v810_intc.sv
// v810 interrupt controller: 16 maskable level/edge sources with priority
// encoding, a shaped NMI pulse and a small register port. Optional input
// synchronizers are enabled by defining V810_INTC_SYNC_EN.
module v810_intc
    import v810_intc_pkg::*;
#(
    parameter int NMI_PULSE = 4
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic [15:0] IRQ,
    input  logic        NMI_REQ,
    input  logic        CSn,
    input  logic        WEn,
    input  logic [1:0]  A,
    input  logic [31:0] DI,
    output logic [31:0] DO,
    output logic        INT,
    output logic [3:0]  INTVn,
    output logic        NMIn
);

    localparam intc_nmi_cnt_t PulseLen = intc_nmi_cnt_t'(NMI_PULSE);

    intc_src_t     irqIn;
    logic          nmiIn;

    intc_src_t     irqSample_q, irqPrev_q;
    intc_src_t     pend_q, pend_d;
    intc_src_t     mask_q, mask_d;
    intc_src_t     edgeMode_q, edgeMode_d;
    intc_src_t     irqRise, pendClr, act;

    logic          regWr, regRd;
    logic [31:0]   rdData;
    logic [31:0]   do_q, do_d;

    logic          prioValid;
    logic [3:0]    prioIdx;
    logic          int_q, int_d;
    logic [3:0]    intvN_q, intvN_d;

    logic          nmiSample_q, nmiPrev_q, nmiRise;
    intc_nmi_cnt_t nmiCnt_q, nmiCnt_d;
    logic          nmiN_q, nmiN_d;

    logic          unusedDi;

`ifdef V810_INTC_SYNC_EN
    intc_src_t irqMeta_q, irqSync_q;
    logic      nmiMeta_q, nmiSync_q;

    // Two-flop synchronizers, advanced on CE like every other register.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            irqMeta_q <= '0;
            irqSync_q <= '0;
            nmiMeta_q <= 1'b0;
            nmiSync_q <= 1'b0;
        end else if (CE) begin
            irqMeta_q <= IRQ;
            irqSync_q <= irqMeta_q;
            nmiMeta_q <= NMI_REQ;
            nmiSync_q <= nmiMeta_q;
        end
    end

    assign irqIn = irqSync_q;
    assign nmiIn = nmiSync_q;
`else
    assign irqIn = IRQ;
    assign nmiIn = NMI_REQ;
`endif

    assign regWr    = ~CSn & ~WEn;
    assign regRd    = ~CSn &  WEn;
    assign unusedDi = ^DI[31:16];

    // Edge bits: a fresh rising edge beats a W1C clear in the same cycle.
    always_comb begin
        irqRise    = irqSample_q & ~irqPrev_q;
        pendClr    = (regWr && (A == INTC_PEND)) ? DI[15:0] : '0;
        pend_d     = (~edgeMode_q & irqSample_q)
                   | ( edgeMode_q & (irqRise | (pend_q & ~pendClr)));
        mask_d     = (regWr && (A == INTC_MASK)) ? DI[15:0] : mask_q;
        edgeMode_d = (regWr && (A == INTC_EDGE)) ? DI[15:0] : edgeMode_q;
    end

    assign act = pend_q & mask_q;

    v810_intc_prio u_prio (
        .src_i   (act),
        .idx_o   (prioIdx),
        .valid_o (prioValid)
    );

    always_comb begin
        int_d   = prioValid;
        intvN_d = prioValid ? ~prioIdx : 4'hF;
    end

    always_comb begin
        rdData = '0;
        case (A)
            INTC_PEND: rdData = intc_zext(pend_q);
            INTC_MASK: rdData = intc_zext(mask_q);
            INTC_EDGE: rdData = intc_zext(edgeMode_q);
            INTC_STAT: rdData = {27'b0, int_q, ~intvN_q};
            default:   rdData = '0;
        endcase
        do_d = regRd ? rdData : do_q;
    end

    // A running pulse swallows further edges; only an idle counter reloads.
    always_comb begin
        nmiRise = nmiSample_q & ~nmiPrev_q;
        if (nmiCnt_q != '0) begin
            nmiCnt_d = nmiCnt_q - intc_nmi_cnt_t'(1);
        end else if (nmiRise) begin
            nmiCnt_d = PulseLen;
        end else begin
            nmiCnt_d = nmiCnt_q;
        end
        nmiN_d = (nmiCnt_q == '0);
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            irqSample_q <= '0;
            irqPrev_q   <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            edgeMode_q  <= '0;
            do_q        <= '0;
            int_q       <= 1'b0;
            intvN_q     <= 4'hF;
            nmiSample_q <= 1'b0;
            nmiPrev_q   <= 1'b0;
            nmiCnt_q    <= '0;
            nmiN_q      <= 1'b1;
        end else if (CE) begin
            irqSample_q <= irqIn;
            irqPrev_q   <= irqSample_q;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            edgeMode_q  <= edgeMode_d;
            do_q        <= do_d;
            int_q       <= int_d;
            intvN_q     <= intvN_d;
            nmiSample_q <= nmiIn;
            nmiPrev_q   <= nmiSample_q;
            nmiCnt_q    <= nmiCnt_d;
            nmiN_q      <= nmiN_d;
        end
    end

    assign DO    = do_q;
    assign INT   = int_q;
    assign INTVn = intvN_q;
    assign NMIn  = nmiN_q;

endmodule
